// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 4-digit multiplexed common-anode display driver.
// All segment and anode patterns are active-low.
package seg7_scan_driver_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   localparam logic [3:0] AN_OFF = 4'b1111;

   typedef enum logic [1:0] {
      SLOT_MIN_U = 2'd0,
      SLOT_MIN_T = 2'd1,
      SLOT_HR_U  = 2'd2,
      SLOT_HR_T  = 2'd3
   } slot_e;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD to active-low 7-segment decoder {g,f,e,d,c,b,a}; non-BCD codes show a dash.
module bcd_to_seg7
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan of HH:MM onto a common-anode display with frame-coherent
// digit capture, whole-display blink, hour leading-zero blanking and a 1 Hz colon.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic [3:0] dig0,
   input  logic [3:0] dig1,
   input  logic [3:0] dig2,
   input  logic [3:0] dig3,
   input  logic       en_afisaj,
   input  logic       palpaie,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
   logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
   slot_e            scan_q, scan_d;
   logic             blink_phase_q, blink_phase_d;
   logic [3:0]       snap_q [4];
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             ref_wrap, blink_wrap, snap_load, visible;
   logic [3:0]       cur_digit;
   logic [6:0]       cur_seg;

   assign cur_digit = snap_q[scan_q];

   bcd_to_seg7 u_dec (
      .bcd_i (cur_digit),
      .seg_o (cur_seg)
   );

   always_comb begin
      ref_wrap      = (ref_cnt_q == REF_LAST);
      blink_wrap    = (blink_cnt_q == BLK_LAST);
      ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLK_W'(1);
      scan_d        = ref_wrap ? slot_e'(scan_q + 2'd1) : scan_q;
      blink_phase_d = blink_phase_q ^ blink_wrap;
      // capture on the 3->0 scan wrap so a whole frame shows one coherent time
      snap_load     = ref_wrap && (scan_q == SLOT_HR_T);

      visible = en_afisaj & ~(palpaie & blink_phase_q);
      an_d    = AN_OFF;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      if (visible) begin
         seg_d = cur_seg;
         if (!((scan_q == SLOT_HR_T) && (snap_q[3] == 4'd0)))
            an_d = ~(4'b0001 << scan_q);
         dp_d = !((scan_q == SLOT_HR_U) && !blink_phase_q);
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ref_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         scan_q        <= SLOT_MIN_U;
         blink_phase_q <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) snap_q[i] <= '0;
         an_q          <= AN_OFF;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
      end else begin
         ref_cnt_q     <= ref_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         scan_q        <= scan_d;
         blink_phase_q <= blink_phase_d;
         if (snap_load) begin
            snap_q[0] <= dig0;
            snap_q[1] <= dig1;
            snap_q[2] <= dig2;
            snap_q[3] <= dig3;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-cycle frame) and BLINK_DIV=64.
module tb_seg7_scan_driver;

   logic       clk = 1'b0;
   logic       reset_;
   logic [3:0] dig0, dig1, dig2, dig3;
   logic       en_afisaj, palpaie;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int tests = 0;
   int fails = 0;
   int k = 0;          // posedges since last reset release
   int prev_low = -1;

   // one record per 16-cycle frame; an/seg/dp packed {slot3,slot2,slot1,slot0}
   typedef struct {
      logic [15:0] dig;
      logic        en;
      logic        pal;
      logic [15:0] an;
      logic [27:0] seg;
      logic [3:0]  dp;
   } frame_t;

   frame_t F [8];

   always #5 clk = ~clk;

   seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .dig0      (dig0),
      .dig1      (dig1),
      .dig2      (dig2),
      .dig3      (dig3),
      .en_afisaj (en_afisaj),
      .palpaie   (palpaie),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es,
                          input logic ed);
      chk({tag, ".an"}, {3'b0, an}, {3'b0, ea});
      chk({tag, ".seg"}, seg, es);
      chk({tag, ".dp"}, {6'b0, dp}, {6'b0, ed});
   endtask

   // advance one edge, sample 1 time unit later, check one-hot anodes and slot ordering
   task automatic step();
      int lows;
      int idx;
      @(posedge clk);
      #1;
      k++;
      lows = 0;
      idx  = -1;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin lows++; idx = i; end
      tests++;
      if (lows > 1) begin
         fails++;
         $display("FAIL onehot k=%0d actual=%b required=at_most_one_low", k, an);
      end
      if (lows == 1 && prev_low >= 0 && idx != prev_low) begin
         tests++;
         if (idx != (prev_low + 1) % 4) begin
            fails++;
            $display("FAIL scan_order k=%0d actual=%0d required=%0d", k, idx, (prev_low + 1) % 4);
         end
      end
      prev_low = (lows == 1) ? idx : -1;
   endtask

   task automatic run_frame(input frame_t f, input string tag);
      {dig3, dig2, dig1, dig0} = f.dig;
      en_afisaj = f.en;
      palpaie   = f.pal;
      for (int s = 0; s < 4; s++)
         for (int c = 0; c < 4; c++) begin
            step();
            chk_out(tag, f.an[s*4 +: 4], f.seg[s*7 +: 7], f.dp[s]);
         end
   endtask

   initial begin
      logic [3:0] exp_an;
      int         phase;
      int         slot;

      F[0] = '{dig:16'h1234, en:1'b1, pal:1'b0, an:16'hFBDE,
               seg:{7'h40, 7'h40, 7'h40, 7'h40}, dp:4'b1011};
      F[1] = '{dig:16'h1234, en:1'b1, pal:1'b0, an:16'h7BDE,
               seg:{7'h79, 7'h24, 7'h30, 7'h19}, dp:4'b1011};
      F[2] = '{dig:16'h093C, en:1'b1, pal:1'b0, an:16'h7BDE,
               seg:{7'h79, 7'h24, 7'h30, 7'h19}, dp:4'b1011};
      F[3] = '{dig:16'h093C, en:1'b1, pal:1'b0, an:16'hFBDE,
               seg:{7'h40, 7'h10, 7'h30, 7'h3F}, dp:4'b1011};
      F[4] = '{dig:16'h5678, en:1'b1, pal:1'b0, an:16'hFBDE,
               seg:{7'h40, 7'h10, 7'h30, 7'h3F}, dp:4'b1111};
      F[5] = '{dig:16'h5678, en:1'b1, pal:1'b0, an:16'h7BDE,
               seg:{7'h12, 7'h02, 7'h78, 7'h00}, dp:4'b1111};
      F[6] = '{dig:16'h1007, en:1'b1, pal:1'b0, an:16'hFBDE,
               seg:{7'h40, 7'h40, 7'h40, 7'h40}, dp:4'b1011};
      F[7] = '{dig:16'h1007, en:1'b1, pal:1'b0, an:16'h7BDE,
               seg:{7'h79, 7'h40, 7'h40, 7'h78}, dp:4'b1011};

      reset_ = 1'b1;
      {dig3, dig2, dig1, dig0} = 16'h0000;
      en_afisaj = 1'b0;
      palpaie   = 1'b0;
      #2 reset_ = 1'b0;
      #1 chk_out("power_on_reset", 4'hF, 7'h7F, 1'b1);
      repeat (3) step();
      @(negedge clk) reset_ = 1'b1;
      k = 0;
      prev_low = -1;

      // frames 0..5: scan, snapshot latency, blanking, dash, colon vs blink phase
      for (int f = 0; f < 6; f++) run_frame(F[f], $sformatf("frame%0d", f));

      // mid-frame digit change must not tear the current frame
      {dig3, dig2, dig1, dig0} = 16'h1002;
      repeat (16) step();
      for (int c = 0; c < 4; c++) begin step(); chk_out("hold_old_digit", 4'hE, 7'h24, 1'b1); end
      repeat (4) step();
      dig0 = 4'h7;
      repeat (8) step();
      for (int c = 0; c < 4; c++) begin step(); chk_out("new_after_wrap", 4'hE, 7'h78, 1'b1); end

      // blinking: dark while blink_phase=1, scanning while 0
      palpaie = 1'b1;
      while (k < 272) begin
         step();
         phase = ((k - 1) / 64) % 2;
         slot  = ((k - 1) / 4) % 4;
         if (phase == 1) chk_out("blink_dark", 4'hF, 7'h7F, 1'b1);
         else begin
            exp_an = ~(4'b0001 << slot);
            chk("blink_lit.an", {3'b0, an}, {3'b0, exp_an});
         end
      end
      while (k < 330) step();
      chk("blink_dark_330.an", {3'b0, an}, 7'h0F);
      palpaie = 1'b0;
      step();
      chk_out("blink_resume", 4'hB, 7'h40, 1'b1);

      en_afisaj = 1'b0;
      repeat (8) begin step(); chk_out("disabled", 4'hF, 7'h7F, 1'b1); end
      en_afisaj = 1'b1;
      step();
      chk_out("reenable", 4'hE, 7'h78, 1'b1);

      // asynchronous reset in the middle of a clock period
      #3 reset_ = 1'b0;
      #1 chk_out("async_reset", 4'hF, 7'h7F, 1'b1);
      repeat (3) begin step(); chk_out("held_in_reset", 4'hF, 7'h7F, 1'b1); end
      @(negedge clk) reset_ = 1'b1;
      k = 0;
      prev_low = -1;
      run_frame(F[6], "post_reset_f0");
      run_frame(F[7], "post_reset_f1");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
